// File: rtl/softex_x_collector_if.sv
// rtl/softex_x_collector_if.sv - data/strb/valid/ready stream bundle for the X collector
//
// Purpose: one stream link between the datapath, the X collector and the hwpe streamer.
// Signals:
//   data  DATA_WIDTH  payload word
//   strb  STRB_WIDTH  byte strobes
//   valid 1           producer holds a beat
//   ready 1           consumer accepts the beat
// Modports: master (drives data/strb/valid), slave (drives ready).
interface softex_x_collector_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;
   logic                  valid;
   logic                  ready;

   modport master (output data, output strb, output valid, input ready);
   modport slave  (input data, input strb, input valid, output ready);
endinterface

// File: rtl/softex_x_collector.sv
// rtl/softex_x_collector.sv - collapses num_loops result beats per X element into one word
//
// Purpose: write-side counterpart of the X loop buffer. Each element arrives as L beats
// (L = num_loops_i, 0 treated as 1); the beats are reduced (last beat, or per-lane unsigned
// max with OR-ed strobes) and the single result is queued in a small FIFO towards the streamer.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   clear_i      synchronous soft clear, same effect as reset
//   num_loops_i  beats per element, stable while busy_o is high
//   busy_o       a partial element is held
//   cnt_o        beat index within the current element
//   buffer_i     input stream from the datapath (slave)
//   buffer_o     collected output stream (master), FIFO head
module softex_x_collector #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned DATA_WIDTH    = DATA_W,
   parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int unsigned LANE_WIDTH    = 16,
   parameter int unsigned BUF_CNT_WIDTH = 8,
   parameter int unsigned CNT_WIDTH     = BUF_CNT_WIDTH,
   parameter int unsigned DEPTH         = 2,
   parameter bit          REDUCE_MAX    = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic [CNT_WIDTH-1:0] num_loops_i,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] cnt_o,
   softex_x_collector_if.slave  buffer_i,
   softex_x_collector_if.master buffer_o
);
   localparam int unsigned N_LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

   logic [CNT_WIDTH-1:0]             cnt_q, cnt_d, last_idx;
   logic [DATA_WIDTH-1:0]            acc_q, acc_d, red_data;
   logic [STRB_WIDTH-1:0]            acc_strb_q, acc_strb_d, red_strb;
   logic [DATA_WIDTH+STRB_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]                   occ_q, occ_d;
   logic                             is_final, fifo_full, in_hs, push, pop;

   // Index of the final beat; a loop count of 0 behaves like 1.
   assign last_idx  = (num_loops_i == '0) ? '0 : num_loops_i - 1'b1;
   assign is_final  = (cnt_q == last_idx);
   assign fifo_full = (occ_q == FULL_OCC);

   // Output comes straight from registered FIFO state: no path from buffer_o.ready.
   assign buffer_o.valid = (occ_q != '0);
   assign {buffer_o.strb, buffer_o.data} = mem_q[rd_ptr_q];

   // Only a final beat needs FIFO space; when full, a same-cycle pop frees the slot.
   assign buffer_i.ready = ~is_final | ~fifo_full | buffer_o.ready;

   assign in_hs = buffer_i.valid & buffer_i.ready;
   assign push  = in_hs & is_final;
   assign pop   = buffer_o.valid & buffer_o.ready;

   assign busy_o = (cnt_q != '0);
   assign cnt_o  = cnt_q;

   // Reduced word including the incoming beat. The first beat of an element loads directly.
   always_comb begin
      red_data = buffer_i.data;
      red_strb = buffer_i.strb;
      if (REDUCE_MAX && (cnt_q != '0)) begin
         red_strb = acc_strb_q | buffer_i.strb;
         for (int unsigned l = 0; l < N_LANES; l++) begin
            if (acc_q[l*LANE_WIDTH +: LANE_WIDTH] > buffer_i.data[l*LANE_WIDTH +: LANE_WIDTH])
               red_data[l*LANE_WIDTH +: LANE_WIDTH] = acc_q[l*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      acc_strb_d = acc_strb_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      if (in_hs) begin
         if (is_final) begin
            cnt_d      = '0;
            acc_d      = '0;
            acc_strb_d = '0;
            wr_ptr_d   = wr_ptr_q + 1'b1;
         end else begin
            cnt_d      = cnt_q + 1'b1;
            acc_d      = red_data;
            acc_strb_d = red_strb;
         end
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         acc_strb_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         acc_strb_q <= acc_strb_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
      end
   end

   // Storage needs no reset: occupancy decides what is visible.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {red_strb, red_data};
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
                    busy_o |-> $stable(num_loops_i))
      else $error("num_loops_i changed while an element is in progress");
`endif
endmodule

// File: tb/tb_softex_x_collector.sv
// tb/tb_softex_x_collector.sv - self-checking bench for softex_x_collector (both reduction modes)
module tb_softex_x_collector;
   localparam int DW    = 32;
   localparam int SW    = DW / 8;
   localparam int LW    = 16;
   localparam int CW    = 8;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst, clr;
   logic [CW-1:0] num_loops;
   logic          busy_last, busy_max;
   logic [CW-1:0] cnt_last, cnt_max;

   softex_x_collector_if #(.DATA_WIDTH(DW)) in_last ();
   softex_x_collector_if #(.DATA_WIDTH(DW)) out_last ();
   softex_x_collector_if #(.DATA_WIDTH(DW)) in_max ();
   softex_x_collector_if #(.DATA_WIDTH(DW)) out_max ();

   softex_x_collector #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .CNT_WIDTH(CW), .DEPTH(DEPTH),
                        .REDUCE_MAX(1'b0)) u_last (
      .clk_i(clk), .rst_i(rst), .clear_i(clr), .num_loops_i(num_loops),
      .busy_o(busy_last), .cnt_o(cnt_last), .buffer_i(in_last), .buffer_o(out_last));

   softex_x_collector #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .CNT_WIDTH(CW), .DEPTH(DEPTH),
                        .REDUCE_MAX(1'b1)) u_max (
      .clk_i(clk), .rst_i(rst), .clear_i(clr), .num_loops_i(num_loops),
      .busy_o(busy_max), .cnt_o(cnt_max), .buffer_i(in_max), .buffer_o(out_max));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: beats of the element in progress and expected FIFO contents.
   logic [DW-1:0] beat_d[$];
   logic [SW-1:0] beat_s[$];
   logic [DW-1:0] q_last_d[$], q_max_d[$];
   logic [SW-1:0] q_last_s[$], q_max_s[$];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      beat_d.delete(); beat_s.delete();
      q_last_d.delete(); q_last_s.delete();
      q_max_d.delete(); q_max_s.delete();
   endtask

   // Drive one cycle of inputs, check all outputs against the model, advance the model.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic ordy, input logic [CW-1:0] nl, input logic c, input logic r);
      int            leff;
      logic          exp_rdy;
      logic [DW-1:0] mx_d;
      logic [SW-1:0] mx_s;
      in_last.valid = v; in_max.valid = v;
      in_last.data  = d; in_max.data  = d;
      in_last.strb  = s; in_max.strb  = s;
      out_last.ready = ordy; out_max.ready = ordy;
      num_loops = nl; clr = c; rst = r;
      #1;
      leff    = (nl == '0) ? 1 : int'(nl);
      exp_rdy = (beat_d.size() != leff - 1) || (q_last_d.size() < DEPTH) || ordy;
      check_eq("last.in_ready", 64'(in_last.ready), 64'(exp_rdy));
      check_eq("max.in_ready",  64'(in_max.ready),  64'(exp_rdy));
      check_eq("last.out_valid", 64'(out_last.valid), 64'(q_last_d.size() != 0));
      check_eq("max.out_valid",  64'(out_max.valid),  64'(q_max_d.size() != 0));
      if (q_last_d.size() != 0) begin
         check_eq("last.out_data", 64'(out_last.data), 64'(q_last_d[0]));
         check_eq("last.out_strb", 64'(out_last.strb), 64'(q_last_s[0]));
      end
      if (q_max_d.size() != 0) begin
         check_eq("max.out_data", 64'(out_max.data), 64'(q_max_d[0]));
         check_eq("max.out_strb", 64'(out_max.strb), 64'(q_max_s[0]));
      end
      check_eq("last.cnt",  64'(cnt_last),  64'(beat_d.size()));
      check_eq("max.cnt",   64'(cnt_max),   64'(beat_d.size()));
      check_eq("last.busy", 64'(busy_last), 64'(beat_d.size() != 0));
      check_eq("max.busy",  64'(busy_max),  64'(beat_d.size() != 0));

      if (r || c) begin
         model_clear();
      end else begin
         if (q_last_d.size() != 0 && ordy) begin
            void'(q_last_d.pop_front()); void'(q_last_s.pop_front());
            void'(q_max_d.pop_front());  void'(q_max_s.pop_front());
         end
         if (v && exp_rdy) begin
            beat_d.push_back(d);
            beat_s.push_back(s);
            if (beat_d.size() == leff) begin
               mx_d = '0;
               mx_s = '0;
               foreach (beat_d[i]) begin
                  mx_s = mx_s | beat_s[i];
                  for (int k = 0; k < DW / LW; k++)
                     if (beat_d[i][k*LW +: LW] > mx_d[k*LW +: LW])
                        mx_d[k*LW +: LW] = beat_d[i][k*LW +: LW];
               end
               q_last_d.push_back(beat_d[$]);
               q_last_s.push_back(beat_s[$]);
               q_max_d.push_back(mx_d);
               q_max_s.push_back(mx_s);
               beat_d.delete();
               beat_s.delete();
            end
         end
      end
      @(negedge clk);
   endtask

   logic [CW-1:0] cur_l;

   initial begin
      in_last.valid = 1'b0; in_max.valid = 1'b0;
      in_last.data = '0; in_max.data = '0;
      in_last.strb = '0; in_max.strb = '0;
      out_last.ready = 1'b0; out_max.ready = 1'b0;
      num_loops = 8'd3; clr = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      model_clear();

      // Reset state, then last-beat behaviour with L=3.
      step(1'b0, '0, '0, 1'b1, 8'd3, 1'b0, 1'b0);
      step(1'b1, 32'hA, 4'hF, 1'b1, 8'd3, 1'b0, 1'b0);
      step(1'b1, 32'hB, 4'hF, 1'b1, 8'd3, 1'b0, 1'b0);
      step(1'b1, 32'hC, 4'hF, 1'b1, 8'd3, 1'b0, 1'b0);
      #1 check_eq("tp.last_first_word", 64'(out_last.data), 64'h0000_000C);
      step(1'b1, 32'hD, 4'hF, 1'b1, 8'd3, 1'b0, 1'b0);
      step(1'b1, 32'hE, 4'hF, 1'b1, 8'd3, 1'b0, 1'b0);
      step(1'b1, 32'hF, 4'hF, 1'b1, 8'd3, 1'b0, 1'b0);
      #1 check_eq("tp.last_second_word", 64'(out_last.data), 64'h0000_000F);

      // Per-lane max with OR-ed strobes, L=4.
      step(1'b1, 32'h0000_0003, 4'h1, 1'b1, 8'd4, 1'b0, 1'b0);
      step(1'b1, 32'h0000_8000, 4'h2, 1'b1, 8'd4, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0010, 4'h0, 1'b1, 8'd4, 1'b0, 1'b0);
      step(1'b1, 32'h0000_7FFF, 4'h4, 1'b1, 8'd4, 1'b0, 1'b0);
      #1 check_eq("tp.max_lane0", 64'(out_max.data[15:0]), 64'h8000);
      check_eq("tp.max_strb", 64'(out_max.strb), 64'h7);

      // Backpressure with L=1 and the output stalled.
      step(1'b0, '0, '0, 1'b1, 8'd1, 1'b0, 1'b0);
      step(1'b1, 32'd1, 4'h1, 1'b0, 8'd1, 1'b0, 1'b0);
      step(1'b1, 32'd2, 4'h2, 1'b0, 8'd1, 1'b0, 1'b0);
      step(1'b1, 32'd3, 4'h3, 1'b0, 8'd1, 1'b0, 1'b0);
      #1 check_eq("tp.bp_stall", 64'(in_last.ready), 64'h0);
      step(1'b1, 32'd3, 4'h3, 1'b1, 8'd1, 1'b0, 1'b0);
      step(1'b1, 32'd4, 4'h4, 1'b0, 8'd1, 1'b0, 1'b0);
      repeat (3) step(1'b1, 32'd5, 4'h5, 1'b1, 8'd1, 1'b0, 1'b0);
      repeat (3) step(1'b0, '0, '0, 1'b1, 8'd1, 1'b0, 1'b0);

      // L=0 behaves like L=1.
      step(1'b1, 32'd1, 4'hF, 1'b1, 8'd0, 1'b0, 1'b0);
      #1 check_eq("tp.l0_word", 64'(out_last.data), 64'h1);
      check_eq("tp.l0_cnt", 64'(cnt_last), 64'h0);
      step(1'b1, 32'd2, 4'hF, 1'b1, 8'd0, 1'b0, 1'b0);
      step(1'b1, 32'd3, 4'hF, 1'b1, 8'd0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 8'd0, 1'b0, 1'b0);

      // Clear in the middle of an element, with a concurrent valid beat.
      step(1'b1, 32'h11, 4'h1, 1'b1, 8'd4, 1'b0, 1'b0);
      step(1'b1, 32'h22, 4'h2, 1'b1, 8'd4, 1'b0, 1'b0);
      step(1'b1, 32'h33, 4'h4, 1'b1, 8'd4, 1'b1, 1'b0);
      #1 check_eq("tp.clr_cnt", 64'(cnt_last), 64'h0);
      check_eq("tp.clr_valid", 64'(out_last.valid), 64'h0);
      for (int i = 0; i < 4; i++) step(1'b1, 32'(i + 'h40), 4'h8, 1'b1, 8'd4, 1'b0, 1'b0);
      repeat (2) step(1'b0, '0, '0, 1'b1, 8'd4, 1'b0, 1'b0);

      // Reset with a full FIFO and a partial element.
      for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 7), 4'hF, 1'b0, 8'd3, 1'b0, 1'b0);
      #1 check_eq("tp.rst_pre_cnt", 64'(cnt_last), 64'h2);
      step(1'b0, '0, '0, 1'b0, 8'd3, 1'b0, 1'b1);
      #1 check_eq("tp.rst_valid", 64'(out_last.valid), 64'h0);
      check_eq("tp.rst_busy", 64'(busy_last), 64'h0);
      check_eq("tp.rst_cnt", 64'(cnt_max), 64'h0);

      // Randomized traffic against the model.
      cur_l = 8'd2;
      for (int i = 0; i < 3000; i++) begin
         if (beat_d.size() == 0 && $urandom_range(0, 9) == 0) cur_l = CW'($urandom_range(0, 5));
         step(1'($urandom_range(0, 9) < 7), DW'($urandom), SW'($urandom),
              1'($urandom_range(0, 1)), cur_l,
              1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 199) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
